// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - state encodings and ICW/OCW bit positions for the ICW sequencer
package pic_pkg;

  localparam logic [2:0] ST_UNINIT    = 3'd0;
  localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
  localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
  localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;

  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

  function automatic logic [2:0] after_icw2(input logic single, input logic ic4);
    if (!single)  return ST_WAIT_ICW3;
    else if (ic4) return ST_WAIT_ICW4;
    else          return ST_READY;
  endfunction

  function automatic logic [2:0] after_icw3(input logic ic4);
    return ic4 ? ST_WAIT_ICW4 : ST_READY;
  endfunction

endpackage

// File: rtl/strobe_edge.sv
// rtl/strobe_edge.sv - one-shot accept pulse on the rising edge of a write strobe
module strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic pulse
);

  logic strobe_q;
  logic armed;

  // armed stays low until the strobe has been seen low once after reset,
  // so a strobe already high at reset release is never taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      strobe_q <= strobe;
      armed    <= armed | ~strobe;
    end
  end

  assign pulse = strobe & ~strobe_q & armed;

endmodule

// File: rtl/icw_sequencer.sv
// rtl/icw_sequencer.sv - PIC ICW/OCW write sequencer; PIC_CASCADE_EN enables the ICW3/cascade path
module icw_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       ICW_1,
  input  logic       ICW_2,
  input  logic       ICW_4,
  input  logic       OCW_1,
  input  logic       OCW_2,
  input  logic       OCW_3,
  input  logic [7:0] internal_bus,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       single,
  output logic       ic4,
  output logic [7:0] cascade_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic       ms,
  output logic       buf_mode,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [7:0] ocw2_data,
  output logic       rd_isr,
  output logic       smm,
  output logic       icw1_pulse,
  output logic       init_done
);
  import pic_pkg::*;

  logic       dw;
  logic       any_s;
  logic       accept;
  logic [2:0] state;

  assign dw    = ICW_2 | ICW_4 | OCW_1;
  assign any_s = dw | ICW_1 | OCW_2 | OCW_3;

  strobe_edge u_strobe_edge (
    .clk    (clk),
    .reset  (reset),
    .strobe (any_s),
    .pulse  (accept)
  );

`ifdef PIC_CASCADE_EN
  logic       single_q;
  logic [7:0] cascade_q;
  assign single      = single_q;
  assign cascade_cfg = cascade_q;
`else
  assign single      = 1'b1;
  assign cascade_cfg = 8'h00;
`endif

  assign init_done = (state == ST_READY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_UNINIT;
      vector_base <= '0;
      ltim        <= 1'b0;
      ic4         <= 1'b0;
      upm         <= 1'b0;
      aeoi        <= 1'b0;
      ms          <= 1'b0;
      buf_mode    <= 1'b0;
      sfnm        <= 1'b0;
      imr         <= '0;
      ocw2_valid  <= 1'b0;
      ocw2_data   <= '0;
      rd_isr      <= 1'b0;
      smm         <= 1'b0;
      icw1_pulse  <= 1'b0;
`ifdef PIC_CASCADE_EN
      single_q    <= 1'b0;
      cascade_q   <= '0;
`endif
    end else begin
      ocw2_valid <= 1'b0;
      icw1_pulse <= 1'b0;
      if (accept) begin
        // ICW1 wins over every other strobe accepted in the same cycle.
        if (ICW_1) begin
          ltim       <= internal_bus[ICW1_LTIM];
          ic4        <= internal_bus[ICW1_IC4];
          imr        <= '0;
          smm        <= 1'b0;
          upm        <= 1'b0;
          aeoi       <= 1'b0;
          ms         <= 1'b0;
          buf_mode   <= 1'b0;
          sfnm       <= 1'b0;
          rd_isr     <= 1'b0;
          icw1_pulse <= 1'b1;
          state      <= ST_WAIT_ICW2;
`ifdef PIC_CASCADE_EN
          single_q   <= internal_bus[ICW1_SNGL];
          cascade_q  <= '0;
`endif
        end else begin
          case (state)
            ST_WAIT_ICW2: if (dw) begin
              vector_base <= internal_bus[7:3];
              state       <= after_icw2(single, ic4);
            end
`ifdef PIC_CASCADE_EN
            ST_WAIT_ICW3: if (dw) begin
              cascade_q <= internal_bus;
              state     <= after_icw3(ic4);
            end
`endif
            ST_WAIT_ICW4: if (dw) begin
              upm      <= internal_bus[ICW4_UPM];
              aeoi     <= internal_bus[ICW4_AEOI];
              ms       <= internal_bus[ICW4_MS];
              buf_mode <= internal_bus[ICW4_BUF];
              sfnm     <= internal_bus[ICW4_SFNM];
              state    <= ST_READY;
            end
            ST_READY: begin
              if (dw) imr <= internal_bus;
              if (OCW_2) begin
                ocw2_data  <= internal_bus;
                ocw2_valid <= 1'b1;
              end
              if (OCW_3) begin
                if (internal_bus[OCW3_RR])   rd_isr <= internal_bus[OCW3_RIS];
                if (internal_bus[OCW3_ESMM]) smm    <= internal_bus[OCW3_SMM];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_icw_sequencer.sv
// tb/tb_icw_sequencer.sv - directed self-checking bench for icw_sequencer (either PIC_CASCADE_EN build)
module tb_icw_sequencer;

`ifdef PIC_CASCADE_EN
  localparam logic CASC = 1'b1;
`else
  localparam logic CASC = 1'b0;
`endif

  localparam int S_ICW1 = 1, S_ICW2 = 2, S_ICW4 = 4, S_OCW1 = 5, S_OCW2 = 6, S_OCW3 = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       icw_1 = 0, icw_2 = 0, icw_4 = 0, ocw_1 = 0, ocw_2 = 0, ocw_3 = 0;
  logic [7:0] bus = 8'h00;
  logic [4:0] vector_base;
  logic       ltim, single, ic4, upm, aeoi, ms, buf_mode, sfnm;
  logic [7:0] cascade_cfg, imr, ocw2_data;
  logic       ocw2_valid, rd_isr, smm, icw1_pulse, init_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  icw_sequencer dut (
    .clk(clk), .reset(reset),
    .ICW_1(icw_1), .ICW_2(icw_2), .ICW_4(icw_4),
    .OCW_1(ocw_1), .OCW_2(ocw_2), .OCW_3(ocw_3),
    .internal_bus(bus),
    .vector_base(vector_base), .ltim(ltim), .single(single), .ic4(ic4),
    .cascade_cfg(cascade_cfg),
    .upm(upm), .aeoi(aeoi), .ms(ms), .buf_mode(buf_mode), .sfnm(sfnm),
    .imr(imr), .ocw2_valid(ocw2_valid), .ocw2_data(ocw2_data),
    .rd_isr(rd_isr), .smm(smm), .icw1_pulse(icw1_pulse), .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic put(input int s, input logic [7:0] d);
    @(negedge clk);
    bus = d;
    case (s)
      S_ICW1: icw_1 = 1'b1;
      S_ICW2: icw_2 = 1'b1;
      S_ICW4: icw_4 = 1'b1;
      S_OCW1: ocw_1 = 1'b1;
      S_OCW2: ocw_2 = 1'b1;
      S_OCW3: ocw_3 = 1'b1;
      default: ;
    endcase
  endtask

  task automatic drop();
    @(negedge clk);
    {icw_1, icw_2, icw_4, ocw_1, ocw_2, ocw_3} = '0;
  endtask

  task automatic wr(input int s, input logic [7:0] d);
    put(s, d);
    drop();
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_vector_base", {3'b0, vector_base}, 8'h00);
    chk("rst_imr", imr, 8'h00);
    chk("rst_init_done", {7'b0, init_done}, 8'h00);
    chk("rst_single", {7'b0, single}, CASC ? 8'h00 : 8'h01);
    chk("rst_ocw2_data", ocw2_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // data-port write in UNINIT is ignored
    wr(S_OCW1, 8'hFF);
    chk("uninit_imr", imr, 8'h00);
    chk("uninit_init_done", {7'b0, init_done}, 8'h00);

    // single-mode init with ICW4, OCW2 ignored in WAIT_ICW2
    put(S_ICW1, 8'h13);
    @(negedge clk);
    chk("icw1_pulse_hi", {7'b0, icw1_pulse}, 8'h01);
    chk("icw1_ic4", {7'b0, ic4}, 8'h01);
    chk("icw1_ltim", {7'b0, ltim}, 8'h00);
    chk("icw1_single", {7'b0, single}, 8'h01);
    drop();
    chk("icw1_pulse_lo", {7'b0, icw1_pulse}, 8'h00);
    put(S_OCW2, 8'h20);
    @(negedge clk);
    chk("wicw2_ocw2_valid", {7'b0, ocw2_valid}, 8'h00);
    drop();
    chk("wicw2_ocw2_data", ocw2_data, 8'h00);
    wr(S_ICW2, 8'h40);
    chk("icw2_vector_base", {3'b0, vector_base}, 8'h08);
    chk("icw2_not_ready", {7'b0, init_done}, 8'h00);
    wr(S_ICW4, 8'h03);
    chk("icw4_upm", {7'b0, upm}, 8'h01);
    chk("icw4_aeoi", {7'b0, aeoi}, 8'h01);
    chk("icw4_init_done", {7'b0, init_done}, 8'h01);

    // OCW1 held 5 cycles with bus changing after the first: one acceptance
    put(S_OCW1, 8'hA5);
    @(negedge clk);
    bus = 8'h5A;
    repeat (4) @(negedge clk);
    {icw_1, icw_2, icw_4, ocw_1, ocw_2, ocw_3} = '0;
    @(negedge clk);
    chk("ocw1_imr", imr, 8'hA5);

    // OCW2 pulse exactly one cycle, data held
    put(S_OCW2, 8'h20);
    @(negedge clk);
    chk("ocw2_valid_hi", {7'b0, ocw2_valid}, 8'h01);
    chk("ocw2_data", ocw2_data, 8'h20);
    @(negedge clk);
    chk("ocw2_valid_lo", {7'b0, ocw2_valid}, 8'h00);
    drop();
    chk("ocw2_data_hold", ocw2_data, 8'h20);

    // OCW3 read-select and special mask, then ICW1 clears them
    wr(S_OCW3, 8'h0B);
    chk("ocw3_rd_isr", {7'b0, rd_isr}, 8'h01);
    chk("ocw3_smm_keep", {7'b0, smm}, 8'h00);
    wr(S_OCW3, 8'h68);
    chk("ocw3_smm", {7'b0, smm}, 8'h01);
    chk("ocw3_rd_isr_keep", {7'b0, rd_isr}, 8'h01);
    put(S_ICW1, 8'h13);
    @(negedge clk);
    chk("reinit_pulse", {7'b0, icw1_pulse}, 8'h01);
    chk("reinit_imr", imr, 8'h00);
    chk("reinit_smm", {7'b0, smm}, 8'h00);
    chk("reinit_rd_isr", {7'b0, rd_isr}, 8'h00);
    chk("reinit_upm", {7'b0, upm}, 8'h00);
    chk("reinit_init_done", {7'b0, init_done}, 8'h00);
    drop();
    chk("reinit_pulse_lo", {7'b0, icw1_pulse}, 8'h00);

    // mid-sequence restart, then cascade sequence (or ICW3 byte landing in ICW4)
    wr(S_ICW2, 8'h20);
    chk("mid_not_ready", {7'b0, init_done}, 8'h00);
    wr(S_ICW1, 8'h11);
    chk("casc_single", {7'b0, single}, CASC ? 8'h00 : 8'h01);
    chk("casc_ic4", {7'b0, ic4}, 8'h01);
    wr(S_ICW2, 8'h20);
    chk("casc_vector_base", {3'b0, vector_base}, 8'h04);
    chk("casc_after2_ready", {7'b0, init_done}, 8'h00);
    wr(S_ICW4, 8'h04);
    chk("casc_cfg", cascade_cfg, CASC ? 8'h04 : 8'h00);
    chk("casc_after3_ready", {7'b0, init_done}, CASC ? 8'h00 : 8'h01);
    chk("casc_after3_ms", {7'b0, ms}, CASC ? 8'h00 : 8'h01);
    wr(S_ICW4, 8'h01);
    chk("casc_after4_ready", {7'b0, init_done}, 8'h01);
    chk("casc_after4_upm", {7'b0, upm}, CASC ? 8'h01 : 8'h00);
    chk("casc_after4_imr", imr, CASC ? 8'h00 : 8'h01);

    // ICW1 priority over OCW1 in the same cycle
    wr(S_OCW1, 8'hC3);
    chk("prio_pre_imr", imr, 8'hC3);
    @(negedge clk);
    bus = 8'h13;
    icw_1 = 1'b1;
    ocw_1 = 1'b1;
    @(negedge clk);
    chk("prio_pulse", {7'b0, icw1_pulse}, 8'h01);
    chk("prio_imr", imr, 8'h00);
    chk("prio_init_done", {7'b0, init_done}, 8'h00);
    drop();

    // async reset in WAIT_ICW4, strobe held across deassertion
    wr(S_ICW2, 8'h40);
    chk("pre_rst_ic4", {7'b0, ic4}, 8'h01);
    chk("pre_rst_vector_base", {3'b0, vector_base}, 8'h08);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_vector_base", {3'b0, vector_base}, 8'h00);
    chk("async_rst_ic4", {7'b0, ic4}, 8'h00);
    bus = 8'h13;
    icw_1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("held_pulse", {7'b0, icw1_pulse}, 8'h00);
    @(negedge clk);
    chk("held_ic4", {7'b0, ic4}, 8'h00);
    drop();
    wr(S_ICW1, 8'h13);
    chk("post_rst_ic4", {7'b0, ic4}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icw_sequencer.md
ICW_SEQUENCER -- requirements
Module: icw_sequencer

Interface
REQ-001 Macro PIC_CASCADE_EN, default undefined, compiles in the ICW3/cascade path.
REQ-002 clk  input  1  single clock; every input below is synchronous to clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ICW_1, ICW_2, ICW_4, OCW_1, OCW_2, OCW_3  input  1 each  write strobes from bus control, level-high for the whole write.
REQ-005 internal_bus  input  8  write data, valid while any strobe is high.
REQ-006 vector_base  output  5  ICW2 D7..D3.
REQ-007 ltim, single, ic4  output  1 each  ICW1 D3, D1, D0.
REQ-008 cascade_cfg  output  8  ICW3 byte.
REQ-009 upm, aeoi, ms, buf_mode, sfnm  output  1 each  ICW4 D0..D4.
REQ-010 imr  output  8  OCW1 interrupt mask.
REQ-011 ocw2_valid  output  1; ocw2_data  output  8  one-cycle OCW2 command pulse.
REQ-012 rd_isr  output  1  1 = status reads return ISR, 0 = IRR.
REQ-013 smm  output  1  special mask mode.
REQ-014 icw1_pulse  output  1  one-cycle pulse per accepted ICW1.
REQ-015 init_done  output  1  high only in READY.

Function
REQ-016 Data-port write (DW) SHALL be ICW_2|ICW_4|OCW_1; any-strobe S = DW|ICW_1|OCW_2|OCW_3.
REQ-017 A write SHALL be accepted only in the cycle where S=1 and registered S was 0; one action per write, however long the strobe is held.
REQ-018 Accepted writes SHALL update state and registers at that clk edge; outputs visible next cycle (latency 1).
REQ-019 States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-020 Accepted ICW_1 in any state SHALL: load ltim/single/ic4; clear imr, smm, cascade_cfg, upm/aeoi/ms/buf_mode/sfnm; set rd_isr=0; pulse icw1_pulse; go WAIT_ICW2.
REQ-021 WAIT_ICW2 + DW: load vector_base=bus[7:3]; next = WAIT_ICW3 if single=0 (cascade built), else WAIT_ICW4 if ic4=1, else READY.
REQ-022 WAIT_ICW3 + DW: load cascade_cfg; next = WAIT_ICW4 if ic4=1 else READY.
REQ-023 WAIT_ICW4 + DW: load ICW4 bits 4..0; next READY.
REQ-024 READY + DW: imr=bus.
REQ-025 READY + OCW_2: ocw2_data=bus, ocw2_valid=1 for exactly one cycle.
REQ-026 READY + OCW_3: if bus[1]=1 then rd_isr=bus[0]; if bus[6]=1 then smm=bus[5]; otherwise unchanged.
REQ-027 OCW_2/OCW_3 outside READY, and DW in UNINIT, SHALL be ignored.
REQ-028 ICW_1 SHALL take priority over any other strobe accepted in the same cycle.
REQ-029 ICW1 received mid-sequence SHALL restart from WAIT_ICW2 with no partial ICW state retained beyond REQ-020.
REQ-030 ocw2_data SHALL hold its last value after ocw2_valid drops.

Reset
REQ-031 reset SHALL force UNINIT, all outputs 0, registered S=0, without clk.
REQ-032 A strobe already high when reset deasserts SHALL NOT be accepted until it drops and rises again.

Configuration
REQ-033 PIC_CASCADE_EN defined: REQ-021/022 as written.
REQ-034 PIC_CASCADE_EN undefined: WAIT_ICW3 unreachable, single output forced 1, cascade_cfg tied 0, ICW1 D1 ignored.

Structure
REQ-035 Shared package pic_pkg SHALL hold state encodings and ICW/OCW bit-position constants.
REQ-036 One sub-module strobe_edge (registered 0->1 detector with async reset) SHALL produce the accept pulse.

Verification
REQ-037 ICW1=0x13, ICW2=0x40, ICW4=0x03 -> vector_base=0x08, aeoi=1, upm=1, init_done=1, WAIT_ICW3 skipped.
REQ-038 ICW1=0x11, ICW2=0x20, ICW3=0x04, ICW4=0x01 (cascade built) -> cascade_cfg=0x04, init_done after 4th write; undefined build -> ICW3 byte lands in ICW4.
REQ-039 READY, OCW1=0xA5 strobe held 5 cycles -> imr=0xA5, one acceptance; OCW2=0x20 -> ocw2_valid exactly 1 cycle, ocw2_data=0x20.
REQ-040 READY, OCW3=0x0B -> rd_isr=1; OCW3=0x68 -> smm=1; then ICW1=0x13 -> imr=0, smm=0, rd_isr=0, icw1_pulse 1 cycle.
REQ-041 reset asserted in WAIT_ICW4 -> UNINIT immediately, all outputs 0; strobe held across deassertion ignored.
REQ-042 OCW2=0x20 in WAIT_ICW2 -> no ocw2_valid, state unchanged.
